// File: rtl/sram_line_controller.sv
// sram_line_controller
// Sequences an off-chip 16-bit asynchronous SRAM on behalf of the data cache.
// A line fill reads four 16-bit beats and assembles a 64-bit line. A
// write-through store writes two 16-bit beats. Each beat lasts WAIT_CYCLES
// clocks.
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   MEM_R_EN         memory stage issues a load this cycle
//   MEM_W_EN         memory stage issues a store this cycle
//   RD_EN_SRAM       active-low line-fill request from the cache
//   WR_EN_SRAM       active-low write request from the cache
//   address          byte address from the memory stage (held while paused)
//   writeData        store data (held while paused)
//   pause_SRAM       combinational freeze: transaction pending or in progress
//   readyFlagData64B one-cycle pulse: outData_SRAM holds a fresh line
//   outData_SRAM     assembled 64-bit line
//   SRAM_ADDR        SRAM word address
//   SRAM_DQ          bidirectional SRAM data bus
//   SRAM_WE_N        SRAM write strobe, active-low
module sram_line_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic               RD_EN_SRAM,
  input  logic               WR_EN_SRAM,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic               pause_SRAM,
  output logic               readyFlagData64B,
  output logic [63:0]        outData_SRAM,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N
);

  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_k;
  logic               r_h;
  logic [WCW-1:0]     r_wait;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [15:0]        r_dq_out;
  logic               r_ready;
  logic [63:0]        r_data;

  state_t             w_state_nxt;
  logic [1:0]         w_k_nxt;
  logic               w_h_nxt;
  logic [WCW-1:0]     w_wait_nxt;
  logic [SRAM_AW-1:0] w_addr_nxt;
  logic               w_we_n_nxt;
  logic               w_dq_oe_nxt;
  logic [15:0]        w_dq_out_nxt;
  logic               w_ready_nxt;
  logic               w_cap;
  logic               w_last_wait;

  // Address bits outside the SRAM word range are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{address[31:19], address[1:0]};

  assign w_last_wait = (r_wait == WCW'(WAIT_CYCLES - 1));

  // Freeze is released during DONE so the cache's request registers clear.
  assign pause_SRAM = !rst && (MEM_R_EN || MEM_W_EN) && (r_state != S_DONE);

  assign SRAM_DQ          = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR        = r_addr;
  assign SRAM_WE_N        = r_we_n;
  assign readyFlagData64B = r_ready;
  assign outData_SRAM     = r_data;

  // Next state, beat/wait counters, and the pin values for the next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_h_nxt      = r_h;
    w_wait_nxt   = r_wait;
    w_ready_nxt  = 1'b0;
    w_cap        = 1'b0;
    w_addr_nxt   = r_addr;
    w_we_n_nxt   = 1'b1;
    w_dq_oe_nxt  = 1'b0;
    w_dq_out_nxt = r_dq_out;

    case (r_state)
      S_IDLE: begin
        if (!RD_EN_SRAM) begin
          w_state_nxt = S_RD;
          w_k_nxt     = 2'd0;
          w_wait_nxt  = '0;
        end else if (!WR_EN_SRAM) begin
          w_state_nxt = S_WR;
          w_h_nxt     = 1'b0;
          w_wait_nxt  = '0;
        end
      end
      S_RD: begin
        w_cap = w_last_wait;
        if (w_last_wait) begin
          w_wait_nxt = '0;
          if (r_k == 2'd3) begin
            w_state_nxt = S_DONE;
            w_ready_nxt = 1'b1;
          end else begin
            w_k_nxt = r_k + 2'd1;
          end
        end else begin
          w_wait_nxt = r_wait + WCW'(1);
        end
      end
      S_WR: begin
        if (w_last_wait) begin
          w_wait_nxt = '0;
          if (r_h) begin
            w_state_nxt = S_DONE;
          end else begin
            w_h_nxt = 1'b1;
          end
        end else begin
          w_wait_nxt = r_wait + WCW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pins are registered, so they are derived from the upcoming state.
    case (w_state_nxt)
      S_RD: begin
        w_addr_nxt = SRAM_AW'({address[18:3], w_k_nxt});
      end
      S_WR: begin
        w_addr_nxt   = SRAM_AW'({address[18:2], w_h_nxt});
        w_dq_oe_nxt  = 1'b1;
        w_dq_out_nxt = w_h_nxt ? writeData[31:16] : writeData[15:0];
        // Strobe released on the final beat cycle to hold data and address.
        w_we_n_nxt   = (w_wait_nxt == WCW'(WAIT_CYCLES - 1));
      end
      default: begin
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= 2'd0;
      r_h      <= 1'b0;
      r_wait   <= '0;
      r_addr   <= '0;
      r_we_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= 16'd0;
      r_ready  <= 1'b0;
      r_data   <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_h      <= w_h_nxt;
      r_wait   <= w_wait_nxt;
      r_addr   <= w_addr_nxt;
      r_we_n   <= w_we_n_nxt;
      r_dq_oe  <= w_dq_oe_nxt;
      r_dq_out <= w_dq_out_nxt;
      r_ready  <= w_ready_nxt;
      if (w_cap) begin
        r_data[{r_k, 4'b0000} +: 16] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_line_controller.sv
// Testbench for sram_line_controller: directed vector table, hand-written
// corner sequences (reset abort, hit, back-to-back) and random transactions
// checked against a word-array reference model of the SRAM contents.
module tb_sram_line_controller;

  localparam int W      = 2;
  localparam int LAT_RD = 4 * W + 2;
  localparam int LAT_WR = 2 * W + 2;
  localparam int WE_LOW = 2 * (W - 1);
  localparam int WIN    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN, RD_EN_SRAM, WR_EN_SRAM;
  logic [31:0] address, writeData;
  logic        pause_SRAM, readyFlagData64B, SRAM_WE_N;
  logic [63:0] outData_SRAM;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;

  sram_line_controller #(.WAIT_CYCLES(W), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .RD_EN_SRAM(RD_EN_SRAM), .WR_EN_SRAM(WR_EN_SRAM), .address(address),
    .writeData(writeData), .pause_SRAM(pause_SRAM),
    .readyFlagData64B(readyFlagData64B), .outData_SRAM(outData_SRAM),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM device on the pins.
  logic [15:0] sram_mem [0:WIN-1];
  logic [15:0] ref_mem  [0:WIN-1];
  logic        sram_oe;
  logic [15:0] sram_rd;
  assign sram_rd = (SRAM_ADDR < 18'(WIN)) ? sram_mem[SRAM_ADDR[9:0]] : 16'h0000;
  assign SRAM_DQ = sram_oe ? sram_rd : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N && SRAM_ADDR < 18'(WIN)) sram_mem[SRAM_ADDR[9:0]] <= SRAM_DQ;

  int tests = 0;
  int fails = 0;
  logic [17:0] addr_log [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a line is four consecutive words, a store two.
  function automatic logic [63:0] ref_line(input logic [31:0] a);
    int b;
    b = int'({a[18:3], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'({a[18:2], 1'b0});
    ref_mem[b]   = d[15:0];
    ref_mem[b+1] = d[31:16];
  endtask

  task automatic check_store(input string name, input logic [31:0] a);
    int b;
    b = int'({a[18:2], 1'b0});
    check({name, "_lo"}, 64'(sram_mem[b]),   64'(ref_mem[b]));
    check({name, "_hi"}, 64'(sram_mem[b+1]), 64'(ref_mem[b+1]));
  endtask

  // Presents one cache request starting at cycle 1 and runs until pause drops
  // (or max_cyc expires); then the cache's request registers clear.
  task automatic run_txn(input logic rd_n, input logic wr_n, input logic mem_r,
                         input logic mem_w, input logic [31:0] a, input logic [31:0] d,
                         input int max_cyc, output int done_cyc, output int ready_cyc,
                         output logic [63:0] ready_data, output int we_low);
    done_cyc = 0; ready_cyc = 0; ready_data = '0; we_low = 0;
    RD_EN_SRAM = rd_n; WR_EN_SRAM = wr_n; MEM_R_EN = mem_r; MEM_W_EN = mem_w;
    address = a; writeData = d; sram_oe = !rd_n;
    for (int c = 1; c <= max_cyc && done_cyc == 0; c++) begin
      @(negedge clk);
      addr_log[c] = SRAM_ADDR;
      if (!SRAM_WE_N) we_low++;
      if (readyFlagData64B) begin
        ready_cyc  = c;
        ready_data = outData_SRAM;
      end
      if (!pause_SRAM) done_cyc = c;
      @(posedge clk); #1;
    end
    RD_EN_SRAM = 1'b1; WR_EN_SRAM = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  typedef struct {
    logic        rd_n, wr_n, mem_r, mem_w;
    logic [31:0] addr, wdata;
    int          exp_done, exp_ready, exp_we;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int dc, rc, wl;
    logic [63:0] rd;
    logic [17:0] a_before;

    for (int i = 0; i < WIN; i++) begin
      sram_mem[i] = 16'hA500 ^ 16'(i);
      ref_mem[i]  = 16'hA500 ^ 16'(i);
    end
    sram_mem[512] = 16'h1111; sram_mem[513] = 16'h2222;
    sram_mem[514] = 16'h3333; sram_mem[515] = 16'h4444;
    ref_mem[512]  = 16'h1111; ref_mem[513]  = 16'h2222;
    ref_mem[514]  = 16'h3333; ref_mem[515]  = 16'h4444;

    //            rd   wr   mr   mw   addr          wdata         done    ready   we      data
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0,        LAT_RD, LAT_RD, 0,      64'h4444_3333_2222_1111};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF, LAT_WR, 0,      WE_LOW, 64'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h12345678, LAT_RD, LAT_RD, 0,      64'hDEAD_BEEF_2222_1111};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFEF00D, LAT_WR, 0,      WE_LOW, 64'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hFFF8_0002, 32'h0,        LAT_RD, LAT_RD, 0,      64'hA503_A502_CAFE_F00D};

    // Reset state (pause must be forced low even with a load pending).
    rst = 1'b1; sram_oe = 1'b0;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; RD_EN_SRAM = 1'b1; WR_EN_SRAM = 1'b1;
    address = '0; writeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_n",  64'(SRAM_WE_N), 64'd1);
    check("rst_ready", 64'(readyFlagData64B), 64'd0);
    check("rst_data",  outData_SRAM, 64'd0);
    check("rst_addr",  64'(SRAM_ADDR), 64'd0);
    check("rst_pause", 64'(pause_SRAM), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; MEM_R_EN = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].rd_n, vecs[i].wr_n, vecs[i].mem_r, vecs[i].mem_w,
              vecs[i].addr, vecs[i].wdata, 40, dc, rc, rd, wl);
      check($sformatf("v%0d_done", i),  64'(dc), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_ready", i), 64'(rc), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_we_low", i), 64'(wl), 64'(vecs[i].exp_we));
      if (vecs[i].exp_ready != 0) begin
        check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
      end else begin
        ref_write(vecs[i].addr, vecs[i].wdata);
        check_store($sformatf("v%0d_mem", i), vecs[i].addr);
      end
      if (i == 0) begin
        for (int c = 2; c <= 9; c++)
          check($sformatf("fill_addr_c%0d", c), 64'(addr_log[c]), 64'(18'h00200 + 18'((c - 2) / 2)));
        check("fill_addr_done", 64'(addr_log[10]), 64'h203);
        repeat (3) @(posedge clk);
        #1 check("fill_data_hold", outData_SRAM, 64'h4444_3333_2222_1111);
      end
      if (i == 1) begin
        for (int c = 2; c <= 5; c++)
          check($sformatf("store_addr_c%0d", c), 64'(addr_log[c]), 64'(18'h00202 + 18'((c - 2) / 2)));
        check("store_word_202", 64'(sram_mem[514]), 64'hBEEF);
        check("store_word_203", 64'(sram_mem[515]), 64'hDEAD);
      end
    end

    // Hit pass-through: freeze asserted, no SRAM activity.
    a_before = SRAM_ADDR;
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0123, 32'h0, 8, dc, rc, rd, wl);
    check("hit_no_done", 64'(dc), 64'd0);
    check("hit_ready",   64'(rc), 64'd0);
    check("hit_we_low",  64'(wl), 64'd0);
    check("hit_addr",    64'(addr_log[8]), 64'(a_before));

    // Back-to-back read miss then store miss.
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 40, dc, rc, rd, wl);
    check("b2b_rd_done", 64'(dc), 64'(LAT_RD));
    check("b2b_rd_data", rd, ref_line(32'h0000_0400));
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0408, 32'h01234567, 40, dc, rc, rd, wl);
    check("b2b_wr_done", 64'(dc), 64'(LAT_WR));
    check("b2b_wr_ready", 64'(rc), 64'd0);
    ref_write(32'h0000_0408, 32'h01234567);
    check_store("b2b_wr_mem", 32'h0000_0408);

    // Reset during read beat 2 aborts without a ready pulse.
    RD_EN_SRAM = 1'b0; MEM_R_EN = 1'b1; address = 32'h0000_0400; sram_oe = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("abort_beat2_addr", 64'(SRAM_ADDR), 64'h202);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pause", 64'(pause_SRAM), 64'd0);
    @(posedge clk); #1;
    check("abort_we_n",  64'(SRAM_WE_N), 64'd1);
    check("abort_ready", 64'(readyFlagData64B), 64'd0);
    check("abort_addr",  64'(SRAM_ADDR), 64'd0);
    rst = 1'b0; RD_EN_SRAM = 1'b1; MEM_R_EN = 1'b0; sram_oe = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (readyFlagData64B) pulses++;
      end
      check("abort_no_pulse", 64'(pulses), 64'd0);
    end
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h55AA33CC, 40, dc, rc, rd, wl);
    check("abort_then_wr_done", 64'(dc), 64'(LAT_WR));
    ref_write(32'h0000_0010, 32'h55AA33CC);
    check_store("abort_then_wr_mem", 32'h0000_0010);

    // Random transactions against the reference model.
    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [31:0] a, d;
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      a[18:11] = '0;
      d = $urandom;
      a_before = SRAM_ADDR;
      case (kind)
        0: run_txn(1'b0, 1'b1, 1'b1, 1'b0, a, d, 40, dc, rc, rd, wl);
        1: run_txn(1'b1, 1'b0, 1'b0, 1'b1, a, d, 40, dc, rc, rd, wl);
        2: run_txn(1'b0, 1'b0, 1'b1, 1'b1, a, d, 40, dc, rc, rd, wl);
        default: run_txn(1'b1, 1'b1, 1'b1, 1'b0, a, d, 6, dc, rc, rd, wl);
      endcase
      if (kind == 3) begin
        check($sformatf("rnd%0d_hit_done", n), 64'(dc), 64'd0);
        check($sformatf("rnd%0d_hit_addr", n), 64'(addr_log[6]), 64'(a_before));
        check($sformatf("rnd%0d_hit_we", n),   64'(wl), 64'd0);
      end else if (kind == 1) begin
        check($sformatf("rnd%0d_wr_done", n),  64'(dc), 64'(LAT_WR));
        check($sformatf("rnd%0d_wr_ready", n), 64'(rc), 64'd0);
        check($sformatf("rnd%0d_wr_we", n),    64'(wl), 64'(WE_LOW));
        ref_write(a, d);
        check_store($sformatf("rnd%0d_wr_mem", n), a);
      end else begin
        check($sformatf("rnd%0d_rd_done", n),  64'(dc), 64'(LAT_RD));
        check($sformatf("rnd%0d_rd_ready", n), 64'(rc), 64'(LAT_RD));
        check($sformatf("rnd%0d_rd_we", n),    64'(wl), 64'd0);
        check($sformatf("rnd%0d_rd_data", n),  rd, ref_line(a));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
